// File: rtl/freq_meter.sv
// freq_meter: measures a slow asynchronous square wave in the clk domain.
// Rising edges are counted over a fixed gate window (frequency), and the
// clk-cycle spacing between consecutive rising edges is timed (period).
// All results are registered and qualified by one-cycle valid strobes.
module freq_meter #(
  parameter int GATE_CYCLES = 2**19,
  parameter int GATE_WIDTH  = 20,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] freq_count,
  output logic                 freq_ovf,
  output logic                 freq_valid,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid
);

  localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  logic                  s1, s2, s3;
  logic                  rise;

  logic [GATE_WIDTH-1:0] gate_cnt;
  logic                  gate_last;

  logic [CNT_WIDTH-1:0]  edge_cnt;
  logic                  edge_ovf;
  logic [CNT_WIDTH:0]    edge_sum;
  logic [CNT_WIDTH-1:0]  edge_next;
  logic                  edge_over;

  logic [CNT_WIDTH-1:0]  per_cnt;
  logic [CNT_WIDTH:0]    per_inc;
  logic [CNT_WIDTH-1:0]  per_next;
  logic                  armed;

  // Two-flop synchronizer plus history flop; free-running regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise      = s2 & ~s3;
  assign gate_last = (gate_cnt == GATE_LAST);

  // Saturating edge-count arithmetic. edge_ovf remembers that a rise arrived
  // while the counter was already pinned at all-ones, so a window whose true
  // count exceeded the range still reports overflow at close.
  always_comb begin
    edge_sum  = {1'b0, edge_cnt} + {{CNT_WIDTH{1'b0}}, rise};
    edge_next = edge_sum[CNT_WIDTH] ? CNT_MAX : edge_sum[CNT_WIDTH-1:0];
    edge_over = edge_ovf | edge_sum[CNT_WIDTH];
  end

  // Gate window: count rises, close the window on the terminal cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      edge_ovf   <= 1'b0;
      freq_count <= '0;
      freq_ovf   <= 1'b0;
      freq_valid <= 1'b0;
    end else if (!en) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      edge_ovf   <= 1'b0;
      freq_valid <= 1'b0;
    end else if (gate_last) begin
      // A rise on the terminal cycle belongs to the window being closed.
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      edge_ovf   <= 1'b0;
      freq_count <= edge_next;
      freq_ovf   <= edge_over;
      freq_valid <= 1'b1;
    end else begin
      gate_cnt   <= gate_cnt + GATE_WIDTH'(1);
      edge_cnt   <= edge_next;
      edge_ovf   <= edge_over;
      freq_valid <= 1'b0;
    end
  end

  // Saturating period arithmetic: period reports cycles between rises.
  always_comb begin
    per_inc  = {1'b0, per_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    per_next = per_inc[CNT_WIDTH] ? CNT_MAX : per_inc[CNT_WIDTH-1:0];
  end

  // Period timer: restart on every rise; the first rise after reset or
  // enable only arms the timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (!en) begin
      per_cnt      <= '0;
      armed        <= 1'b0;
      period_valid <= 1'b0;
    end else if (rise) begin
      per_cnt      <= '0;
      armed        <= 1'b1;
      period_valid <= armed;
      if (armed) begin
        period <= per_next;
      end
    end else begin
      per_cnt      <= per_next;
      period_valid <= 1'b0;
    end
  end

endmodule
